// File: rtl/cla_seq_adder_pkg.sv
// Shared types and constants for the nibble-serial carry-lookahead adder.
package cla_pkg;

  // Controller states: wait for operands, step the slice, hold the result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of the one shared carry-lookahead slice.
  localparam int SLICE_W = 4;

endpackage

// File: rtl/cla_seq_adder_cla.sv
// 4-bit carry-lookahead slice: every carry is built directly from the
// generate/propagate terms and cin, with no ripple between bit positions.
module cla
  import cla_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] s,
  output logic               cout
);

  logic [SLICE_W-1:0] g_s;
  logic [SLICE_W-1:0] p_s;
  logic [SLICE_W:0]   c_s;

  assign g_s = a & b;
  assign p_s = a ^ b;

  assign c_s[0] = cin;
  assign c_s[1] = g_s[0] | (p_s[0] & cin);
  assign c_s[2] = g_s[1] | (p_s[1] & g_s[0]) | (p_s[1] & p_s[0] & cin);
  assign c_s[3] = g_s[2] | (p_s[2] & g_s[1]) | (p_s[2] & p_s[1] & g_s[0])
                | (p_s[2] & p_s[1] & p_s[0] & cin);
  assign c_s[4] = g_s[3] | (p_s[3] & g_s[2]) | (p_s[3] & p_s[2] & g_s[1])
                | (p_s[3] & p_s[2] & p_s[1] & g_s[0])
                | (p_s[3] & p_s[2] & p_s[1] & p_s[0] & cin);

  assign s    = p_s ^ c_s[SLICE_W-1:0];
  assign cout = c_s[SLICE_W];

endmodule

// File: rtl/cla_seq_adder.sv
// Multi-precision add/subtract: one 4-bit CLA slice is reused once per
// nibble, LSB nibble first, with the carry held in a register between steps.
module cla_seq_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NIB   = WIDTH / SLICE_W;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

  generate
    if (((WIDTH % SLICE_W) != 0) || (WIDTH < SLICE_W)) begin : g_width_chk
      $error("cla_seq_adder: WIDTH must be a multiple of 4 and at least 4");
    end
  endgenerate

  state_t             state_r;
  logic [WIDTH-1:0]   opa_r;
  logic [WIDTH-1:0]   opb_r;
  logic               carry_r;
  logic [IDX_W-1:0]   idx_r;
  logic               sub_r;
  logic               a_msb_r;
  logic               b_msb_r;
  logic [WIDTH-1:0]   sum_r;
  logic               cout_r;
  logic               ovf_r;
  logic               in_ready_r;
  logic               out_valid_r;

  logic [SLICE_W-1:0] slice_sum_s;
  logic               slice_cout_s;
  logic [WIDTH-1:0]   sum_next_s;
  logic               last_s;
  logic               bp_msb_s;

  cla u_cla (
    .a    (opa_r[SLICE_W-1:0]),
    .b    (opb_r[SLICE_W-1:0]),
    .cin  (carry_r),
    .s    (slice_sum_s),
    .cout (slice_cout_s)
  );

  // New nibble enters at the top so the LSB nibble lands at bit 0 after NIB steps.
  assign sum_next_s = (sum_r >> SLICE_W) | (WIDTH'(slice_sum_s) << (WIDTH - SLICE_W));
  assign last_s     = (idx_r == IDX_W'(NIB - 1));
  // Sign of the effective B operand: raw B sign, flipped when subtracting.
  assign bp_msb_s   = b_msb_r ^ sub_r;

  // Controller FSM: operand capture, per-nibble stepping and result hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      opa_r       <= '0;
      opb_r       <= '0;
      carry_r     <= 1'b0;
      idx_r       <= '0;
      sub_r       <= 1'b0;
      a_msb_r     <= 1'b0;
      b_msb_r     <= 1'b0;
      sum_r       <= '0;
      cout_r      <= 1'b0;
      ovf_r       <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid && in_ready_r) begin
            opa_r      <= a;
            opb_r      <= sub ? ~b : b;
            carry_r    <= sub;
            idx_r      <= '0;
            sub_r      <= sub;
            a_msb_r    <= a[WIDTH-1];
            b_msb_r    <= b[WIDTH-1];
            in_ready_r <= 1'b0;
            state_r    <= RUN;
          end
        end
        RUN: begin
          sum_r   <= sum_next_s;
          opa_r   <= opa_r >> SLICE_W;
          opb_r   <= opb_r >> SLICE_W;
          carry_r <= slice_cout_s;
          idx_r   <= idx_r + IDX_W'(1);
          if (last_s) begin
            cout_r      <= slice_cout_s;
            ovf_r       <= (a_msb_r == bp_msb_s) && (slice_sum_s[SLICE_W-1] != a_msb_r);
            out_valid_r <= 1'b1;
            state_r     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= IDLE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign sum       = sum_r;
  assign cout      = cout_r;
  assign ovf       = ovf_r;

endmodule

// File: tb/tb_cla_seq_adder.sv
// Directed and reference-model checks of cla_seq_adder at WIDTH 4, 16 and 32.
module tb_cla_seq_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic        iv4 = 1'b0, sub4 = 1'b0, or4 = 1'b0;
  logic [3:0]  a4 = 4'd0, b4 = 4'd0;
  logic        ir4, ov4, c4, o4;
  logic [3:0]  s4;

  logic        iv16 = 1'b0, sub16 = 1'b0, or16 = 1'b0;
  logic [15:0] a16 = 16'd0, b16 = 16'd0;
  logic        ir16, ov16, c16, o16;
  logic [15:0] s16;

  logic        iv32 = 1'b0, sub32 = 1'b0, or32 = 1'b0;
  logic [31:0] a32 = 32'd0, b32 = 32'd0;
  logic        ir32, ov32, c32, o32;
  logic [31:0] s32;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  cla_seq_adder #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
    .sub(sub4), .out_valid(ov4), .out_ready(or4), .sum(s4), .cout(c4), .ovf(o4));

  cla_seq_adder #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
    .sub(sub16), .out_valid(ov16), .out_ready(or16), .sum(s16), .cout(c16), .ovf(o16));

  cla_seq_adder #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32),
    .sub(sub32), .out_valid(ov32), .out_ready(or32), .sum(s32), .cout(c32), .ovf(o32));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int w, input logic iv, input logic [31:0] av,
                       input logic [31:0] bv, input logic sv, input logic rv);
    case (w)
      4:       begin iv4 = iv;  a4 = av[3:0];   b4 = bv[3:0];   sub4 = sv;  or4 = rv;  end
      16:      begin iv16 = iv; a16 = av[15:0]; b16 = bv[15:0]; sub16 = sv; or16 = rv; end
      default: begin iv32 = iv; a32 = av;       b32 = bv;       sub32 = sv; or32 = rv; end
    endcase
  endtask

  task automatic sample(input int w, output logic ir, output logic ov, output logic [31:0] s,
                        output logic c, output logic o);
    case (w)
      4:       begin ir = ir4;  ov = ov4;  s = {28'd0, s4};  c = c4;  o = o4;  end
      16:      begin ir = ir16; ov = ov16; s = {16'd0, s16}; c = c16; o = o16; end
      default: begin ir = ir32; ov = ov32; s = s32;          c = c32; o = o32; end
    endcase
  endtask

  // One full transaction: accept, wait (bounded) for out_valid, handshake, check.
  task automatic op(input string tag, input int w, input logic [31:0] av, input logic [31:0] bv,
                    input logic sv, input logic [31:0] es, input logic ec, input logic eo);
    logic ir, ov, c, o;
    logic [31:0] s;
    int lat;
    drive(w, 1'b1, av, bv, sv, 1'b0);
    @(posedge clk); #1;
    drive(w, 1'b0, av, bv, sv, 1'b0);
    lat = 0;
    sample(w, ir, ov, s, c, o);
    while (!ov && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      sample(w, ir, ov, s, c, o);
    end
    check({tag, " latency"}, 64'(lat), 64'(w / 4));
    check({tag, " sum"}, 64'(s), 64'(es));
    check({tag, " cout"}, 64'(c), 64'(ec));
    check({tag, " ovf"}, 64'(o), 64'(eo));
    drive(w, 1'b0, av, bv, sv, 1'b1);
    @(posedge clk); #1;
    drive(w, 1'b0, av, bv, sv, 1'b0);
    sample(w, ir, ov, s, c, o);
    check({tag, " in_ready after handshake"}, 64'(ir), 64'd1);
    check({tag, " out_valid after handshake"}, 64'(ov), 64'd0);
  endtask

  // Reference model: full-width arithmetic on the effective operands.
  task automatic rand_op(input int w);
    logic [31:0] mask, av, bv, bp, es;
    logic [32:0] full;
    logic sv, ec, eo;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    av   = $urandom() & mask;
    bv   = $urandom() & mask;
    sv   = 1'($urandom_range(0, 1));
    bp   = (sv ? ~bv : bv) & mask;
    full = {1'b0, av} + {1'b0, bp} + {32'd0, sv};
    es   = full[31:0] & mask;
    ec   = full[w];
    eo   = (av[w-1] == bp[w-1]) && (es[w-1] != av[w-1]);
    op((w == 16) ? "rand16" : "rand32", w, av, bv, sv, es, ec, eo);
  endtask

  initial begin
    logic seen_ov;

    // Reset state while rst_n is held low.
    repeat (2) @(posedge clk);
    #1;
    check("reset in_ready16", 64'(ir16), 64'd1);
    check("reset out_valid16", 64'(ov16), 64'd0);
    check("reset sum16", 64'(s16), 64'd0);
    check("reset cout16", 64'(c16), 64'd0);
    check("reset ovf16", 64'(o16), 64'd0);
    check("reset in_ready4", 64'(ir4), 64'd1);
    check("reset in_ready32", 64'(ir32), 64'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors at WIDTH=16.
    op("add 1234+0fcd", 16, 32'h1234, 32'h0FCD, 1'b0, 32'h2201, 1'b0, 1'b0);
    op("add ffff+0001", 16, 32'hFFFF, 32'h0001, 1'b0, 32'h0000, 1'b1, 1'b0);
    op("add 7fff+0001", 16, 32'h7FFF, 32'h0001, 1'b0, 32'h8000, 1'b0, 1'b1);
    op("sub 0005-0007", 16, 32'h0005, 32'h0007, 1'b1, 32'hFFFE, 1'b0, 1'b0);
    op("sub 8000-0001", 16, 32'h8000, 32'h0001, 1'b1, 32'h7FFF, 1'b1, 1'b1);

    // Backpressure, with in_valid/a/b toggled while busy.
    drive(16, 1'b1, 32'h1234, 32'h0FCD, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(16, 1'b1, 32'hFFFF, 32'hFFFF, 1'b1, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    check("bp out_valid at edge 4", 64'(ov16), 64'd1);
    for (int i = 0; i < 3; i++) begin
      a16 = 16'(i * 16'h1111);
      iv16 = ~iv16;
      @(posedge clk); #1;
      check("bp held out_valid", 64'(ov16), 64'd1);
      check("bp held in_ready", 64'(ir16), 64'd0);
      check("bp held sum", 64'(s16), 64'h2201);
      check("bp held cout", 64'(c16), 64'd0);
      check("bp held ovf", 64'(o16), 64'd0);
    end
    drive(16, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    @(posedge clk); #1;
    or16 = 1'b0;
    check("bp in_ready return", 64'(ir16), 64'd1);
    check("bp out_valid drop", 64'(ov16), 64'd0);
    check("bp sum kept in idle", 64'(s16), 64'h2201);

    // Reset pulse during RUN cycle 2 aborts the operation.
    drive(16, 1'b1, 32'h7FFF, 32'h7FFF, 1'b0, 1'b0);
    @(posedge clk); #1;
    iv16 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrun rst out_valid", 64'(ov16), 64'd0);
    check("midrun rst in_ready", 64'(ir16), 64'd1);
    check("midrun rst sum", 64'(s16), 64'd0);
    check("midrun rst cout", 64'(c16), 64'd0);
    check("midrun rst ovf", 64'(o16), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen_ov = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      seen_ov = seen_ov | ov16;
    end
    check("midrun rst no out_valid", 64'(seen_ov), 64'd0);
    op("after rst 0001+0001", 16, 32'h0001, 32'h0001, 1'b0, 32'h0002, 1'b0, 1'b0);

    // WIDTH=4 single-nibble instance.
    op("w4 f+1", 4, 32'hF, 32'h1, 1'b0, 32'h0, 1'b1, 1'b0);
    op("w4 3-5", 4, 32'h3, 32'h5, 1'b1, 32'hE, 1'b0, 1'b0);

    // WIDTH=32 directed carry through every nibble.
    op("w32 ffffffff+1", 32, 32'hFFFF_FFFF, 32'h1, 1'b0, 32'h0, 1'b1, 1'b0);

    // Reference-model sweep.
    for (int i = 0; i < 1000; i++) rand_op(16);
    for (int i = 0; i < 1000; i++) rand_op(32);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cla_seq_adder.md
# cla_seq_adder

Multi-cycle, multi-precision adder/subtractor controller built around one shared 4-bit carry-lookahead slice (`cla`). It accepts a WIDTH-bit operand pair over a valid/ready handshake and sequences the operands through the slice one nibble per cycle, least-significant nibble first. The carry is registered between cycles. The result is held on a valid/ready output until consumed. It sits between the operand-issue logic and any consumer that trades latency for area relative to a full-width CLA tree.

## Interface
- `WIDTH`, 16: operand/result width in bits. Must be a multiple of 4 and ≥ 4; elaboration error otherwise.
- `clk`  in  1  sole clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operand pair and `sub` are valid.
- `in_ready`  out  1  block can accept operands (high only in IDLE).
- `a`  in  WIDTH  operand A.
- `b`  in  WIDTH  operand B.
- `sub`  in  1  0 = A+B, 1 = A−B.
- `out_valid`  out  1  result outputs valid.
- `out_ready`  in  1  consumer accepts result.
- `sum`  out  WIDTH  result modulo 2^WIDTH.
- `cout`  out  1  final carry out. For subtraction, 1 = no borrow.
- `ovf`  out  1  two's-complement signed overflow.

## Operation
- NIB = WIDTH/4 slices. Counter `idx` has width max(1, clog2(NIB)).
- FSM states:
  - IDLE: `in_ready`=1. On `in_valid`&&`in_ready`:
    - capture `a` into `opa`.
    - capture `b` into `opb`, or `~b` when `sub`=1.
    - set `carry` = `sub`.
    - set `idx`=0 and latch `sub_r`.
    - go to RUN.
  - RUN: slice inputs are `opa[3:0]`, `opb[3:0]`, `carry`. Each cycle:
    - shift the slice sum into `sum` from the top (shift right by 4).
    - shift `opa` and `opb` right by 4.
    - set `carry` to the slice Cout.
    - increment `idx`.
    - when `idx`==NIB−1, also go to DONE.
  - DONE: `out_valid`=1. On `out_ready`=1, go to IDLE.
- `cout` is the registered carry after the last slice.
- `ovf` = (A[W−1] == B'[W−1]) && (sum[W−1] != A[W−1]), where B' is the effective (possibly inverted) B. A[W−1] and B'[W−1] are latched from the captured operands at accept.
- `sum`, `cout`, `ovf` are meaningful only while `out_valid`=1. They are held stable in DONE, are not cleared on return to IDLE, and change only during RUN.
- `in_valid` in RUN or DONE is ignored; no operand capture, no error.
- `out_ready` outside DONE is ignored.
- No overlap: a new accept is possible only in the cycle after the DONE handshake.

## Timing
- Reset values: state=IDLE, `in_ready`=1, `out_valid`=0, `sum`=0, `cout`=0, `ovf`=0, `idx`=0, `carry`=0.
- Reset asserted mid-RUN or mid-DONE aborts immediately. Result is discarded, and IDLE is entered on the first edge after release.
- Accept edge = cycle 0. RUN occupies cycles 1..NIB. `out_valid` rises at edge NIB (latency NIB cycles; 4 for WIDTH=16).
- With `out_ready` held high: `out_valid` lasts one cycle, and `in_ready` is high the next cycle.
- Throughput is 1 operation per NIB+2 cycles.
- WIDTH=4: RUN lasts exactly one cycle.

## Structure
- Package `cla_pkg`:
  - state enum {IDLE, RUN, DONE}.
  - constant `SLICE_W`=4.
- Sub-module: one instance of the existing 4-bit `cla` slice. No other arithmetic on the carry path.

## Test plan
- WIDTH=16: A=0x1234, B=0x0FCD, sub=0 → sum=0x2201, cout=0, ovf=0, `out_valid` exactly 4 cycles after accept.
- A=0xFFFF, B=0x0001, sub=0 → sum=0x0000, cout=1, ovf=0. Then A=0x7FFF, B=0x0001 → sum=0x8000, cout=0, ovf=1.
- A=0x0005, B=0x0007, sub=1 → sum=0xFFFE, cout=0, ovf=0. Then A=0x8000, B=0x0001, sub=1 → sum=0x7FFF, cout=1, ovf=1.
- Backpressure:
  - hold `out_ready`=0 for 3 cycles in DONE → outputs stable and `in_ready`=0.
  - toggling `in_valid`/`a` during RUN/DONE changes nothing.
  - `in_ready` returns the cycle after `out_ready`=1.
- Pulse `rst_n` low during RUN cycle 2 → `out_valid` never asserts, all outputs at reset values, next operation (0x0001+0x0001) yields 0x0002.
- WIDTH=4 instance: A=0xF, B=0x1 → sum=0x0, cout=1, latency 1 cycle. Also random A/B/sub (≥1000 ops) against a reference model at WIDTH=16 and WIDTH=32.
